mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Memory-side responder for the pipeline's instruction and data request interfaces. It produces the ihit/dhit/iload/dload signals that the hazard unit consumes to stall or advance stages.
- Arbitrates the fetch (I) and memory-stage (D) requests onto a single-port RAM through a ready/valid-style RAM handshake.
- Data requests take priority, so a load/store in MEM always completes before the next fetch.
- Includes a per-access watchdog that flags a RAM that never responds.

Parameters:
- ADDR_W, 32, byte-address width of iaddr/daddr/ram_addr
- DATA_W, 32, word width of all data buses
- TIMEOUT, 255, max cycles in an access state before err is raised (1..65535)

Ports:
- CLK  input  1  clock, rising edge
- nRST  input  1  asynchronous active-low reset
- iREN  input  1  instruction read request, held until ihit
- iaddr  input  ADDR_W  instruction address
- ihit  output  1  one-cycle pulse: iload valid, I request retired
- iload  output  DATA_W  fetched instruction word, held until next ihit
- dREN  input  1  data read request, held until dhit
- dWEN  input  1  data write request, held until dhit
- daddr  input  ADDR_W  data address
- dstore  input  DATA_W  write data
- dhit  output  1  one-cycle pulse: D request retired
- dload  output  DATA_W  read data, held until next read dhit
- ram_ren  output  1  RAM read strobe
- ram_wen  output  1  RAM write strobe
- ram_addr  output  ADDR_W  RAM address
- ram_wdata  output  DATA_W  RAM write data
- ram_rdata  input  DATA_W  RAM read data, valid when ram_ready
- ram_ready  input  1  RAM completed current access
- err  output  1  sticky watchdog flag

Behaviour:
- Reset (nRST low, async): state IDLE; ihit, dhit, ram_ren, ram_wen, err = 0; iload, dload, ram_addr, ram_wdata = 0; watchdog = 0.
- States: IDLE, DACC, IACC, DONE.
- IDLE: if dWEN|dREN, latch daddr/dstore/op and go to DACC. Else if iREN, latch iaddr and go to IACC. Else stay.
- Write priority: dWEN and dREN both high is treated as a write.
- DACC/IACC: ram_ren/ram_wen/ram_addr/ram_wdata driven from registers (not live inputs); watchdog increments each cycle.
- On ram_ready in DACC/IACC:
  - For reads, capture ram_rdata into dload or iload.
  - Go to DONE; strobes drop in the same transition.
- DONE (exactly 1 cycle): dhit or ihit = 1 per the completed access, then to IDLE.
  - Requests are not sampled in DONE, because the requester is still holding the just-retired request.
- Minimum latency: request seen in IDLE at cycle 0 → ram_ready at cycle 1 → hit asserted in cycle 2. Each extra RAM wait cycle adds 1.
- Back-to-back: a request held in DONE is sampled again in IDLE the following cycle.
  - This is correct because the pipeline deasserts or changes the request on the edge ending the hit cycle.
- ihit and dhit are never high in the same cycle.
- Watchdog:
  - Clears on entry to DACC/IACC.
  - If it reaches TIMEOUT without ram_ready: set err (sticky until reset), drop strobes, go to DONE, and pulse the hit with load = all-ones.
  - This prevents a permanent pipeline stall.
- Request withdrawn mid-access (e.g. pipeline flush on branch): the access still completes and hits. The stale hit is ignored by the consumer. No abort.
- ram_ready in IDLE/DONE is ignored.
- Reset asserted mid-access: strobes drop immediately, the captured access is lost, and no hit is issued.

Test Plan:
- Single read: iREN, iaddr=0x100, ram_ready one cycle after ram_ren with rdata=0x00500093 → ram_addr=0x100, ihit pulses in cycle 2, iload=0x00500093 and holds afterwards.
- Priority: iREN and dREN asserted together (daddr=0x2000, rdata=0xDEADBEEF) → D access first, dhit then dload=0xDEADBEEF, next access iaddr, ihit ≥3 cycles after dhit.
- Write with 3 wait states: dWEN, daddr=0x40, dstore=0xCAFEF00D, ram_ready 3 cycles late → ram_wen high 4 cycles with stable addr/data, dhit one cycle, dload unchanged.
- dREN=dWEN=1 → RAM sees a write only; a single dhit.
- Timeout with TIMEOUT=8: ram_ready tied 0 → after 8 access cycles err=1, hit pulses with load=0xFFFFFFFF, err stays 1 over later successful accesses.
- Reset mid-access: deassert nRST during DACC → all outputs 0 asynchronously; after release, no dhit until a new request completes.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the pipeline request/response signals, the
// single-port RAM handshake and the sticky error flag of mem_arbiter.
//   slave  : the arbiter's view (takes I/D requests and RAM responses,
//            drives hits, loads, RAM strobes and err)
//   master : the environment's view (pipeline + RAM)
// Clock and reset are kept outside the interface as plain ports.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // instruction side
  logic              iREN;
  logic [ADDR_W-1:0] iaddr;
  logic              ihit;
  logic [DATA_W-1:0] iload;
  // data side
  logic              dREN;
  logic              dWEN;
  logic [ADDR_W-1:0] daddr;
  logic [DATA_W-1:0] dstore;
  logic              dhit;
  logic [DATA_W-1:0] dload;
  // RAM side
  logic              ram_ren;
  logic              ram_wen;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              ram_ready;
  // watchdog
  logic              err;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ram_rdata, ram_ready,
    output ihit, iload, dhit, dload, ram_ren, ram_wen, ram_addr, ram_wdata, err
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ram_rdata, ram_ready,
    input  ihit, iload, dhit, dload, ram_ren, ram_wen, ram_addr, ram_wdata, err
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: memory-side responder for the fetch (I) and memory-stage (D)
// request ports. Serialises them onto one single-port RAM, D first, and
// retires each request with a one-cycle ihit/dhit pulse for the hazard unit.
// A per-access watchdog forces completion (load = all-ones, sticky err) if
// the RAM never raises ram_ready.
// Ports:
//   CLK   - clock, rising edge
//   nRST  - asynchronous active-low reset
//   bus   - mem_arbiter_if.slave: iREN/iaddr/ihit/iload, dREN/dWEN/daddr/
//           dstore/dhit/dload, ram_ren/ram_wen/ram_addr/ram_wdata/
//           ram_rdata/ram_ready, err
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255   // 1..65535 access cycles
) (
  input  logic          CLK,
  input  logic          nRST,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, DACC, IACC, DONE} state_t;

  // Watchdog holds the number of access cycles already spent; the cycle in
  // which it equals TIMEOUT-1 is the last one allowed.
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

  state_t            state, state_n;
  logic              op_d;      // current/last access is a D access
  logic              op_w;      // current/last access is a write
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] iload_q;
  logic [DATA_W-1:0] dload_q;
  logic [15:0]       wd;
  logic              err_q;

  logic d_req, in_acc, wd_expired;

  assign d_req      = bus.dREN | bus.dWEN;
  assign in_acc     = (state == DACC) || (state == IACC);
  assign wd_expired = (wd == WD_LAST);

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (d_req)          state_n = DACC;
        else if (bus.iREN)  state_n = IACC;
      end
      // ram_ready wins over an expiring watchdog in the same cycle
      DACC, IACC: if (bus.ram_ready || wd_expired) state_n = DONE;
      // requests are not sampled here: the requester still holds the one
      // being retired
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state   <= IDLE;
      op_d    <= 1'b0;
      op_w    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      iload_q <= '0;
      dload_q <= '0;
      wd      <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: begin
          wd <= '0;   // fresh count on every access entry
          if (d_req) begin
            op_d    <= 1'b1;
            op_w    <= bus.dWEN;  // dREN+dWEN together is a write
            addr_q  <= bus.daddr;
            wdata_q <= bus.dstore;
          end else if (bus.iREN) begin
            op_d   <= 1'b0;
            op_w   <= 1'b0;
            addr_q <= bus.iaddr;
          end
        end
        DACC, IACC: begin
          wd <= wd + 16'd1;
          if (bus.ram_ready) begin
            if (!op_w) begin
              if (op_d) dload_q <= bus.ram_rdata;
              else      iload_q <= bus.ram_rdata;
            end
          end else if (wd_expired) begin
            // dead RAM: retire with a poison word so the pipeline moves on
            err_q <= 1'b1;
            if (op_d) dload_q <= '1;
            else      iload_q <= '1;
          end
        end
        default: ;
      endcase
    end
  end

  // Strobes come from state + latched op, so they drop with the DONE
  // transition and immediately on reset.
  assign bus.ram_ren   = in_acc && !op_w;
  assign bus.ram_wen   = in_acc &&  op_w;
  assign bus.ram_addr  = addr_q;
  assign bus.ram_wdata = wdata_q;
  assign bus.ihit      = (state == DONE) && !op_d;
  assign bus.dhit      = (state == DONE) &&  op_d;
  assign bus.iload     = iload_q;
  assign bus.dload     = dload_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  localparam int TO = 8;

  logic CLK = 1'b0;
  logic nRST;
  always #5 CLK = ~CLK;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .CLK(CLK), .nRST(nRST), .bus(bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference memory: words written through the arbiter; unwritten
  // addresses return a fixed address-derived pattern.
  logic [31:0] mem [logic [31:0]];
  logic [31:0] model_iload = '0;
  logic [31:0] model_dload = '0;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'h5A5A_0F0F;
  endfunction

  // One pipeline transaction: optional I request and/or D request held until
  // their hits, with the RAM answering after wd/wi wait cycles. Expectations
  // come from the protocol rules: D first, hit at 2+waits (or 1+TO on a dead
  // RAM), the I access starting the cycle after dhit.
  task automatic run_txn(input bit ir, input bit dr, input bit dw,
                         input logic [31:0] ia, input logic [31:0] da,
                         input logic [31:0] ds, input int wd, input int wi,
                         input bit exp_err, input string tag);
    bit dq, ip, dp, td_to, ti_to, strobe;
    int td, ti, cyc, cnt, d_str, i_str;
    logic [31:0] exp_dl, exp_il;
    dq = dr | dw; ip = ir; dp = dq;
    td_to = (wd >= TO); ti_to = (wi >= TO);
    td = dq ? (td_to ? 1 + TO : 2 + wd) : -1;
    ti = ir ? ((dq ? td + 1 : 0) + (ti_to ? 1 + TO : 2 + wi)) : -1;
    exp_dl = model_dload;
    if (dq && !dw) exp_dl = td_to ? 32'hFFFF_FFFF : mem_rd(da);
    if (dw && !td_to) mem[da] = ds;
    exp_il = ir ? (ti_to ? 32'hFFFF_FFFF : mem_rd(ia)) : model_iload;
    bus.iREN = ir; bus.iaddr = ia;
    bus.dREN = dr; bus.dWEN = dw; bus.daddr = da; bus.dstore = ds;
    cyc = 0; cnt = 0; d_str = 0; i_str = 0;
    while ((ip || dp) && cyc < 60) begin
      @(posedge CLK); #1;
      cyc++;
      chk({tag, " hit_exclusive"}, 64'(bus.ihit & bus.dhit), 64'(0));
      if (bus.dhit) begin
        chk({tag, " dhit_wanted"}, 64'(dp), 64'(1));
        chk({tag, " dhit_cycle"}, 64'(cyc), 64'(td));
        chk({tag, " dload"}, 64'(bus.dload), 64'(exp_dl));
        chk({tag, " d_strobe_cycles"}, 64'(d_str), 64'(td_to ? TO : wd + 1));
        dp = 0; bus.dREN = 0; bus.dWEN = 0;
      end
      if (bus.ihit) begin
        chk({tag, " ihit_wanted"}, 64'(ip), 64'(1));
        chk({tag, " ihit_cycle"}, 64'(cyc), 64'(ti));
        chk({tag, " iload"}, 64'(bus.iload), 64'(exp_il));
        chk({tag, " i_strobe_cycles"}, 64'(i_str), 64'(ti_to ? TO : wi + 1));
        ip = 0; bus.iREN = 0;
      end
      strobe = bus.ram_ren | bus.ram_wen;
      if (strobe) begin
        cnt++;
        if (dp) begin
          d_str++;
          chk({tag, " d_ram_strobes"}, 64'({bus.ram_ren, bus.ram_wen}), 64'({!dw, dw}));
          chk({tag, " d_ram_addr"}, 64'(bus.ram_addr), 64'(da));
          if (dw) chk({tag, " d_ram_wdata"}, 64'(bus.ram_wdata), 64'(ds));
          bus.ram_ready = (cnt > wd);
        end else begin
          i_str++;
          chk({tag, " i_ram_strobes"}, 64'({bus.ram_ren, bus.ram_wen}), 64'(2'b10));
          chk({tag, " i_ram_addr"}, 64'(bus.ram_addr), 64'(ia));
          bus.ram_ready = (cnt > wi);
        end
        bus.ram_rdata = bus.ram_ready ? mem_rd(bus.ram_addr) : $urandom;
      end else begin
        cnt = 0;
        // stray ready/data outside an access must be ignored
        bus.ram_ready = 1'($urandom_range(0, 1));
        bus.ram_rdata = $urandom;
      end
    end
    chk({tag, " wait_bound"}, 64'({ip, dp}), 64'(0));
    chk({tag, " err"}, 64'(bus.err), 64'(exp_err));
    bus.ram_ready = 0;
    @(posedge CLK); #1;
    chk({tag, " hit_single_cycle"}, 64'({bus.ihit, bus.dhit}), 64'(0));
    chk({tag, " iload_held"}, 64'(bus.iload), 64'(exp_il));
    chk({tag, " dload_held"}, 64'(bus.dload), 64'(exp_dl));
    model_iload = exp_il;
    model_dload = exp_dl;
  endtask

  typedef struct {
    bit          ir, dr, dw;
    logic [31:0] ia, da, ds;
    int          wd, wi;
    bit          exp_err;
  } vec_t;

  vec_t tbl [10];

  task automatic run_vec(input int k);
    run_txn(tbl[k].ir, tbl[k].dr, tbl[k].dw, tbl[k].ia, tbl[k].da, tbl[k].ds,
            tbl[k].wd, tbl[k].wi, tbl[k].exp_err, $sformatf("vec%0d", k));
  endtask

  initial begin
    //          ir dr dw  ia          da          ds            wd  wi  err
    tbl[0] = '{1, 0, 0, 32'h100, 32'h0,    32'h0,          0,  0,  0}; // single fetch
    tbl[1] = '{1, 1, 0, 32'h104, 32'h2000, 32'h0,          0,  0,  0}; // D before I
    tbl[2] = '{0, 0, 1, 32'h0,   32'h40,   32'hCAFEF00D,   3,  0,  0}; // write, 3 waits
    tbl[3] = '{0, 1, 0, 32'h0,   32'h40,   32'h0,          1,  0,  0}; // read back
    tbl[4] = '{0, 1, 1, 32'h0,   32'h44,   32'h12345678,   0,  0,  0}; // ren+wen = write
    tbl[5] = '{0, 1, 0, 32'h0,   32'h44,   32'h0,          2,  0,  0};
    tbl[6] = '{1, 0, 0, 32'h200, 32'h0,    32'h0,          0,  TO-1, 0}; // last legal cycle
    tbl[7] = '{1, 0, 0, 32'h300, 32'h0,    32'h0,          0,  100, 1}; // I timeout
    tbl[8] = '{0, 1, 0, 32'h0,   32'h48,   32'h0,          50, 0,  1}; // D timeout
    tbl[9] = '{1, 1, 0, 32'h100, 32'h2000, 32'h0,          1,  0,  1}; // err stays sticky
    mem[32'h100]  = 32'h00500093;
    mem[32'h2000] = 32'hDEADBEEF;

    nRST = 0;
    bus.iREN = 0; bus.iaddr = '0; bus.dREN = 0; bus.dWEN = 0;
    bus.daddr = '0; bus.dstore = '0; bus.ram_ready = 0; bus.ram_rdata = '0;
    #12;
    chk("reset_strobes_hits_err",
        64'({bus.ram_ren, bus.ram_wen, bus.ihit, bus.dhit, bus.err}), 64'(0));
    chk("reset_ram_addr", 64'(bus.ram_addr), 64'(0));
    chk("reset_ram_wdata", 64'(bus.ram_wdata), 64'(0));
    chk("reset_loads", {bus.iload, bus.dload}, 64'(0));
    #5 nRST = 1;
    @(posedge CLK); #1;

    for (int k = 0; k <= 6; k++) run_vec(k);

    for (int n = 0; n < 40; n++) begin
      int pat;
      logic [31:0] ia, da, ds;
      pat = $urandom_range(0, 3);
      ia  = 32'h1000 + 32'(4 * $urandom_range(0, 15));
      da  = 32'h8000 + 32'(4 * $urandom_range(0, 7));
      ds  = $urandom;
      case (pat)
        0: run_txn(1, 0, 0, ia, da, ds, 0, $urandom_range(0, 4), 0, "rnd_i");
        1: run_txn(0, 1, 0, ia, da, ds, $urandom_range(0, 4), 0, 0, "rnd_dr");
        2: run_txn(0, 0, 1, ia, da, ds, $urandom_range(0, 4), 0, 0, "rnd_dw");
        default: run_txn(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)) | 1'b0,
                         ia, da, ds, $urandom_range(0, 4), $urandom_range(0, 4), 0, "rnd_id");
      endcase
    end

    for (int k = 7; k <= 9; k++) run_vec(k);

    // reset in the middle of a D access
    bus.dREN = 1; bus.daddr = 32'h80; bus.ram_ready = 0;
    @(posedge CLK); #1;
    chk("rst_mid_in_access", 64'(bus.ram_ren), 64'(1));
    #2 nRST = 0;
    #1;
    chk("rst_mid_strobes_hits_err",
        64'({bus.ram_ren, bus.ram_wen, bus.ihit, bus.dhit, bus.err}), 64'(0));
    chk("rst_mid_ram_addr", 64'(bus.ram_addr), 64'(0));
    chk("rst_mid_loads", {bus.iload, bus.dload}, 64'(0));
    bus.dREN = 0;
    model_iload = '0;
    model_dload = '0;
    #3 nRST = 1;
    for (int c = 0; c < 5; c++) begin
      @(posedge CLK); #1;
      chk("rst_no_stale_hit", 64'({bus.ihit, bus.dhit, bus.ram_ren}), 64'(0));
    end
    run_txn(0, 1, 0, 32'h0, 32'h80, 32'h0, 1, 0, 0, "post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
